// File: rtl/mdio_arbiter_pkg.sv
// Shared definitions for the MDIO arbiter: Clause-22 opcode values, frame
// field positions and the arbiter FSM encoding.
package mdio_arbiter_pkg;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int OP_MSB   = 29;
    localparam int OP_LSB   = 28;
    localparam int WR_EDGES = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/mdio_rr_pick.sv
// Rotate-priority picker: first set request searching upward from ptr+1,
// wrapping modulo N_REQ. Purely combinational.
module mdio_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign gnt[gi] = any && (idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO transaction generator between N_REQ
// requesters; tracks frame completion and returns read data or an error.
module mdio_arbiter
    import mdio_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [15:0]          rsp_data,
    output logic                 err,
    output logic                 mdio_start,
    output logic [31:0]          t_data,
    input  logic                 mdc,
    input  logic                 data_rdy,
    input  logic [15:0]          rd_data
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    arb_state_t        state_reg, state_next;
    logic [IW-1:0]     ptr_reg, win_idx_reg;
    logic [N_REQ-1:0]  gnt_reg;
    logic [31:0]       t_data_reg;
    logic [15:0]       rsp_data_reg;
    logic              err_flag_reg;
    logic              mdc_q_reg;
    logic [5:0]        edge_cnt_reg;
    logic [TW-1:0]     tmo_cnt_reg;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [31:0]       frame [N_REQ];
    logic [31:0]       pick_frame;
    logic [1:0]        cur_op;
    logic              mdc_rise, read_done, write_done, timed_out;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_frame
            assign frame[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    mdio_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign pick_frame = frame[pick_idx];
    assign cur_op     = t_data_reg[OP_MSB:OP_LSB];
    assign mdc_rise   = mdc & ~mdc_q_reg;
    assign read_done  = data_rdy && (cur_op == OP_READ);
    assign write_done = mdc_rise && (cur_op == OP_WRITE) && (edge_cnt_reg == 6'(WR_EDGES - 1));
    assign timed_out  = (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    // Illegal opcodes never reach the generator
                    state_next = op_is_legal(pick_frame[OP_MSB:OP_LSB]) ? ST_START : ST_DONE;
                end
            end
            ST_START: state_next = ST_BUSY;
            ST_BUSY: begin
                if (read_done || write_done || timed_out) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            win_idx_reg  <= '0;
            gnt_reg      <= '0;
            t_data_reg   <= '0;
            rsp_data_reg <= '0;
            err_flag_reg <= 1'b0;
            mdc_q_reg    <= 1'b0;
            edge_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            mdc_q_reg <= mdc;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_reg      <= pick_gnt;
                        win_idx_reg  <= pick_idx;
                        t_data_reg   <= pick_frame;
                        rsp_data_reg <= '0;
                        err_flag_reg <= ~op_is_legal(pick_frame[OP_MSB:OP_LSB]);
                    end
                end
                ST_START: begin
                    edge_cnt_reg <= '0;
                    tmo_cnt_reg  <= '0;
                end
                ST_BUSY: begin
                    tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    if (mdc_rise) begin
                        edge_cnt_reg <= edge_cnt_reg + 6'd1;
                    end
                    // Completion takes precedence over a coincident timeout
                    if (read_done) begin
                        rsp_data_reg <= rd_data;
                    end else if (!write_done && timed_out) begin
                        err_flag_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    ptr_reg <= win_idx_reg;
                    gnt_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign gnt        = gnt_reg;
    assign done       = (state_reg == ST_DONE) ? gnt_reg : '0;
    assign err        = (state_reg == ST_DONE) && err_flag_reg;
    assign mdio_start = (state_reg == ST_START);
    assign rsp_data   = rsp_data_reg;
    assign t_data     = t_data_reg;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Bench for mdio_arbiter: table of single transactions scored through a queue,
// plus sequences for timeout, reset mid-frame and round-robin ordering.
module tb_mdio_arbiter;
    import mdio_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   gnt, done;
    logic [15:0]  rsp_data;
    logic         err, mdio_start;
    logic [31:0]  t_data;
    logic         mdc, data_rdy;
    logic [15:0]  rd_data;

    logic [3:0]   t_req, t_gnt, t_done;
    logic [15:0]  t_rsp;
    logic         t_err, t_start;
    logic [31:0]  t_tdata;

    always #5 clk = ~clk;

    mdio_arbiter #(.N_REQ(4), .TIMEOUT_CYC(4096)) u_dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .rsp_data(rsp_data), .err(err),
        .mdio_start(mdio_start), .t_data(t_data),
        .mdc(mdc), .data_rdy(data_rdy), .rd_data(rd_data)
    );

    mdio_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) u_tmo (
        .clk(clk), .reset(reset), .req(t_req), .req_data(req_data),
        .gnt(t_gnt), .done(t_done), .rsp_data(t_rsp), .err(t_err),
        .mdio_start(t_start), .t_data(t_tdata),
        .mdc(mdc), .data_rdy(data_rdy), .rd_data(rd_data)
    );

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic [15:0] rdval;
        logic [15:0] exp_rsp;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [3:0]  done;
        logic [15:0] rsp;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   n_starts = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] make_frame(input logic [1:0] op, input logic [4:0] phy,
                                               input logic [4:0] ra, input logic [15:0] d);
        return {2'b01, op, phy, ra, 2'b10, d};
    endfunction

    // Scoreboard: every done pulse of the main instance is matched in order
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (mdio_start) n_starts++;
            if (|done) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done=%b, required no done", done);
                end else begin
                    e = sb.pop_front();
                    if ({done, rsp_data, err} !== e) begin
                        n_fail++;
                        $display("FAIL sb_txn: got done=%b rsp=%h err=%b, required done=%b rsp=%h err=%b",
                                 done, rsp_data, err, e.done, e.rsp, e.err);
                    end else begin
                        $display("txn done=%b rsp_data=%h err=%b", done, rsp_data, err);
                    end
                end
            end
        end
    end

    task automatic wait_done(input int budget, output int waited);
        waited = -1;
        for (int i = 0; i < budget; i++) begin
            if (|done) begin
                waited = i;
                break;
            end
            tick();
        end
    endtask

    task automatic do_write(output int early);
        early = 0;
        for (int e = 1; e <= 32; e++) begin
            mdc = 1'b0;
            tick();
            if (|done) early++;
            mdc = 1'b1;
            tick();
            if (e < 32 && |done) early++;
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic [31:0] frame;
        exp_t        e;
        int          w, early, starts0;
        logic        legal;
        frame  = make_frame(v.op, v.phy, v.regad, v.wdata);
        legal  = (v.op == OP_READ) || (v.op == OP_WRITE);
        e.done = 4'(1) << v.idx;
        e.rsp  = v.exp_rsp;
        e.err  = v.exp_err;
        sb.push_back(e);
        starts0 = n_starts;
        req_data[32*v.idx +: 32] = frame;
        req[v.idx] = 1'b1;
        tick();
        if (legal) begin
            check("start_latency", mdio_start, 1);
            check("gnt", gnt, e.done);
            check("t_data", t_data, frame);
            if (v.op == OP_READ) begin
                repeat (3) tick();
                check("busy_no_done", done, 0);
                data_rdy = 1'b1;
                rd_data  = v.rdval;
                tick();
                data_rdy = 1'b0;
                rd_data  = 16'h0;
                wait_done(1, w);
                check("read_done_cycle", w, 0);
            end else begin
                do_write(early);
                check("write_early", early, 0);
                check("write_done_on_32", done, e.done);
            end
        end else begin
            check("illegal_no_start", mdio_start, 0);
            wait_done(2, w);
            check("illegal_done_by_2", (w == 0 || w == 1), 1);
            check("illegal_err", err, 1);
        end
        req[v.idx] = 1'b0;
        tick();
        tick();
        check("start_count", n_starts - starts0, legal ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        vec_t        v;
        logic [3:0]  rr_order[5];
        logic [3:0]  ors;
        int          lat, early;

        tbl[0] = '{idx:2, op:OP_READ,  phy:5'h01, regad:5'h02, wdata:16'h0000, rdval:16'hBEEF, exp_rsp:16'hBEEF, exp_err:1'b0};
        tbl[1] = '{idx:0, op:OP_WRITE, phy:5'h01, regad:5'h00, wdata:16'h1234, rdval:16'h0000, exp_rsp:16'h0000, exp_err:1'b0};
        tbl[2] = '{idx:1, op:2'b11,    phy:5'h02, regad:5'h03, wdata:16'h0000, rdval:16'h0000, exp_rsp:16'h0000, exp_err:1'b1};
        tbl[3] = '{idx:3, op:OP_READ,  phy:5'h1F, regad:5'h1F, wdata:16'h0000, rdval:16'h5A5A, exp_rsp:16'h5A5A, exp_err:1'b0};
        tbl[4] = '{idx:1, op:2'b00,    phy:5'h04, regad:5'h05, wdata:16'hFFFF, rdval:16'h0000, exp_rsp:16'h0000, exp_err:1'b1};
        tbl[5] = '{idx:2, op:OP_WRITE, phy:5'h07, regad:5'h09, wdata:16'hABCD, rdval:16'h0000, exp_rsp:16'h0000, exp_err:1'b0};

        reset = 1'b1; req = '0; t_req = '0; req_data = '0;
        mdc = 1'b0; data_rdy = 1'b0; rd_data = '0;
        repeat (3) tick();
        check("reset_outputs", {gnt, done, err, mdio_start, rsp_data, t_data}, 0);
        check("reset_outputs_tmo", {t_gnt, t_done, t_err, t_start, t_rsp, t_tdata}, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Timeout on requester 1, then requester 2 completes on the timeout cycle
        req_data[63:32] = make_frame(OP_READ, 5'h03, 5'h04, 16'h0);
        req_data[95:64] = make_frame(OP_READ, 5'h03, 5'h05, 16'h0);
        t_req = 4'b0110;
        tick();
        check("tmo_start", t_start, 1);
        check("tmo_gnt_first", t_gnt, 4'b0010);
        lat = 0;
        while (!(|t_done) && lat < 40) begin
            tick();
            lat++;
        end
        check("tmo_latency", lat, 17);
        check("tmo_done", t_done, 4'b0010);
        check("tmo_err", t_err, 1);
        check("tmo_rsp", t_rsp, 0);
        t_req[1] = 1'b0;
        tick();
        tick();
        check("tmo_next_start", t_start, 1);
        check("tmo_gnt_second", t_gnt, 4'b0100);
        ors = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            ors |= t_done;
        end
        check("tmo_tie_no_early_done", ors, 0);
        data_rdy = 1'b1;
        rd_data  = 16'hCAFE;
        tick();
        data_rdy = 1'b0;
        rd_data  = 16'h0;
        check("tie_done", t_done, 4'b0100);
        check("tie_err", t_err, 0);
        check("tie_rsp", t_rsp, 16'hCAFE);
        t_req = '0;
        tick();
        tick();

        // Reset while a read is in BUSY
        req_data[63:32] = make_frame(OP_READ, 5'h06, 5'h07, 16'h0);
        req[1] = 1'b1;
        tick();
        check("rst_pre_start", mdio_start, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_outputs", {gnt, done, err, mdio_start, rsp_data, t_data}, 0);
        reset = 1'b0;
        req[1] = 1'b0;
        tick();
        data_rdy = 1'b1;
        rd_data  = 16'h7777;
        tick();
        data_rdy = 1'b0;
        rd_data  = 16'h0;
        ors = '0;
        for (int i = 0; i < 3; i++) begin
            ors |= done;
            tick();
        end
        check("rst_no_late_done", ors, 0);
        v = '{idx:3, op:OP_READ, phy:5'h02, regad:5'h01, wdata:16'h0, rdval:16'h0F0F, exp_rsp:16'h0F0F, exp_err:1'b0};
        run_txn(v);

        // Round robin with all requests held; last winner was 3
        rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            req_data[32*i +: 32] = make_frame(OP_WRITE, 5'h0A, 5'(i), 16'h1000 + 16'(i));
        end
        for (int t = 0; t < 5; t++) begin
            sb.push_back('{done: rr_order[t], rsp: 16'h0, err: 1'b0});
        end
        req = 4'b1111;
        tick();
        for (int t = 0; t < 5; t++) begin
            check("rr_start", mdio_start, 1);
            check("rr_gnt", gnt, rr_order[t]);
            do_write(early);
            check("rr_early", early, 0);
            check("rr_done", done, rr_order[t]);
            if (t == 4) req = '0;
            tick();
            check("rr_idle_gap", {mdio_start, gnt}, 0);
            if (t < 4) tick();
        end
        repeat (3) tick();

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
